output_port_allocator: RTL and testbench

//  - Per-output-port allocator: shares one router output link among PORT_NUM input ports in wormhole fashion.
//  - Inputs whose route computation selects this port raise a head request; round-robin picks one owner.
//  - The owner holds the link from its head flit through its tail flit.
//  - Downstream buffer space is tracked with credits. One instance per output port (NORTH/SOUTH/EAST/WEST/LOCAL).
//  - Drives crossbar select and input-buffer pop.

---
 rtl/noc_pkg.sv | 28 ++
 rtl/output_port_allocator_rr_arbiter.sv | 34 +++
 rtl/output_port_allocator.sv | 164 ++++++++++++++++
 tb/tb_output_port_allocator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port count, port numbering and the
// output-allocator state encoding.
package noc_pkg;

    // Number of router ports competing for each output link.
    localparam int PORT_NUM = 5;

    // Router port numbering; the enum value is the port index.
    typedef enum logic [2:0] {
        NORTH = 3'd0,
        SOUTH = 3'd1,
        EAST  = 3'd2,
        WEST  = 3'd3,
        LOCAL = 3'd4
    } port_t;

    // Output allocator states: link free for arbitration, or held by a packet.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    // Index width for an N-way select; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : noc_pkg

// File: rtl/output_port_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: scans req_i circularly starting at
// ptr_i and returns the first requester as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Circular priority scan; the first hit wins and later hits are masked.
    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/output_port_allocator.sv
// Per-output-port wormhole allocator. In IDLE the inputs with a head flit
// routed here compete round-robin; the winner is granted in the same cycle
// and owns the link until its tail flit crosses. A credit counter mirrors
// the free space in the downstream input buffer; no flit is sent without
// a credit.
//
// Handshake: grant_o[i] is a pop strobe for input i and coincides with
// out_valid_o; a flit crosses in exactly the cycles where out_valid_o=1.
// credit_i is a one-cycle pulse per freed downstream slot and takes effect
// from the following cycle.
//
// Build option ARB_HEADTAIL_EN: when defined, a single-flit packet (head and
// tail in one flit) is granted in IDLE and the allocator stays IDLE. When
// undefined, head and tail never coincide and every IDLE grant locks.
module output_port_allocator #(
    parameter int PORT_NUM    = noc_pkg::PORT_NUM,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORT_NUM-1:0]         head_req_i,
    input  logic [PORT_NUM-1:0]         flit_valid_i,
    input  logic [PORT_NUM-1:0]         tail_i,
    input  logic                        credit_i,
    output logic [PORT_NUM-1:0]         grant_o,
    output logic [$clog2(PORT_NUM)-1:0] xb_sel_o,
    output logic                        out_valid_o,
    output logic                        locked_o
);

    import noc_pkg::*;

    localparam int IW = $clog2(PORT_NUM);
    localparam int CW = $clog2(BUFFER_SIZE + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(BUFFER_SIZE);
    localparam logic [IW-1:0] LAST_IDX   = IW'(PORT_NUM - 1);

    // Registered allocator state.
    alloc_state_t  state_q,   state_d;
    logic [IW-1:0] owner_q,   owner_d;
    logic [IW-1:0] rr_ptr_q,  rr_ptr_d;
    logic [CW-1:0] credits_q, credits_d;

    // Combinational decisions for the current cycle.
    logic [PORT_NUM-1:0] arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    logic                can_send;
    logic                transfer;
    logic [PORT_NUM-1:0] grant;
    logic [IW-1:0]       sel;

    // A credit pulse only refills the counter, so sending depends on the
    // registered count alone.
    assign can_send = (credits_q != '0);

    rr_arbiter #(
        .N  (PORT_NUM),
        .IW (IW)
    ) u_rr_arbiter (
        .req_i (head_req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Next-state, ownership and grant selection.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant    = '0;
        sel      = owner_q;
        transfer = 1'b0;
        case (state_q)
            IDLE: begin
                // Zero-latency grant: the winning head flit crosses now.
                if (arb_any && can_send) begin
                    grant    = arb_gnt;
                    sel      = arb_idx;
                    transfer = 1'b1;
                    owner_d  = arb_idx;
                    rr_ptr_d = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
`ifdef ARB_HEADTAIL_EN
                    // A single-flit packet releases the link as it is sent.
                    state_d  = tail_i[arb_idx] ? IDLE : LOCKED;
`else
                    state_d  = LOCKED;
`endif
                end
            end
            LOCKED: begin
                // Only the owner moves; other heads wait for the tail.
                if (flit_valid_i[owner_q] && can_send) begin
                    grant[owner_q] = 1'b1;
                    transfer       = 1'b1;
                    if (tail_i[owner_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Credit accounting: a send consumes one slot, a returned credit frees
    // one; both together leave the count unchanged.
    always_comb begin
        credits_d = credits_q;
        case ({transfer, credit_i})
            2'b10: credits_d = credits_q - 1'b1;
            2'b01: credits_d = (credits_q == CREDIT_MAX) ? CREDIT_MAX
                                                         : credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    // State, ownership, round-robin pointer and credit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            credits_q <= CREDIT_MAX;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            credits_q <= credits_d;
        end
    end

    // Outputs are held at zero for the whole time reset is asserted, even
    // though IDLE would otherwise grant a pending head combinationally.
    assign grant_o     = rst_n ? grant : '0;
    assign out_valid_o = rst_n & transfer;
    assign xb_sel_o    = rst_n ? sel : '0;
    assign locked_o    = rst_n & (state_q == LOCKED);

    // A credit returned while the counter is already full means the
    // downstream buffer reported more slots than it has.
    a_credit_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(credit_i && !transfer && (credits_q == CREDIT_MAX))
    );

    // The link carries at most one flit per cycle.
    a_grant_onehot: assert property (
        @(posedge clk) disable iff (!rst_n)
        $onehot0(grant_o) && (out_valid_o == |grant_o)
    );

`ifndef ARB_HEADTAIL_EN
    // Without single-flit packets a head flit can never also be a tail.
    a_no_headtail: assert property (
        @(posedge clk) disable iff (!rst_n)
        (head_req_i & tail_i) == '0
    );
`endif

endmodule : output_port_allocator

// File: tb/tb_output_port_allocator.sv
// Bench for output_port_allocator: per-input flit queues feed the DUT, a
// downstream occupancy model returns credits, and an abstract allocator
// model predicts each cycle's grant into a scoreboard queue.
module tb_output_port_allocator;

  localparam int N  = 5;
  localparam int BS = 8;
  localparam int EW = N + 3 + 1;

  // Clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] head_req_i = '0;
  logic [N-1:0] flit_valid_i = '0;
  logic [N-1:0] tail_i = '0;
  logic         credit_i = 1'b0;
  logic [N-1:0] grant_o;
  logic [2:0]   xb_sel_o;
  logic         out_valid_o;
  logic         locked_o;

  output_port_allocator #(.PORT_NUM(N), .BUFFER_SIZE(BS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .head_req_i   (head_req_i),
    .flit_valid_i (flit_valid_i),
    .tail_i       (tail_i),
    .credit_i     (credit_i),
    .grant_o      (grant_o),
    .xb_sel_o     (xb_sel_o),
    .out_valid_o  (out_valid_o),
    .locked_o     (locked_o)
  );

  int checks = 0;
  int errors = 0;

  // Expected per-cycle response: {grant, sel, locked}
  logic [EW-1:0] exp_q[$];

  // Upstream flit queues, each entry {is_head, is_tail}
  logic [1:0] fq[N][$];

  // Reference model state
  int owner = -1;      // -1: link free
  int rr = 0;          // first input to consider in the next arbitration
  int credits = BS;
  int occ = 0;         // flits sitting in the downstream buffer
  bit credit_mode = 1'b0;
  int credit_pct = 50;
  bit force_credit = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic add_pkt(input int port, input int len);
    for (int k = 0; k < len; k++) begin
      fq[port].push_back({(k == 0), (k == len - 1)});
    end
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) begin
      if (fq[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Driver: one cycle of stimulus plus its predicted response
  task automatic step();
    logic [N-1:0] hr, fv, tl, eg;
    logic cr;
    int g, j;
    bit tl_g;
    @(negedge clk);
    cr = 1'b0;
    if (occ > 0 && (force_credit || (credit_mode && $urandom_range(0, 99) < credit_pct)))
      cr = 1'b1;
    force_credit = 1'b0;
    hr = '0; fv = '0; tl = '0;
    for (int i = 0; i < N; i++) begin
      if (fq[i].size() > 0) begin
        fv[i] = 1'b1;
        hr[i] = fq[i][0][1];
        tl[i] = fq[i][0][0];
      end
    end
    head_req_i = hr;
    flit_valid_i = fv;
    tail_i = tl;
    credit_i = cr;

    g = -1;
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        j = (rr + k) % N;
        if (g < 0 && hr[j]) g = j;
      end
    end else if (fv[owner]) begin
      g = owner;
    end
    if (credits == 0) g = -1;
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    exp_q.push_back({eg, 3'((g >= 0) ? g : 0), (owner >= 0)});

    if (g >= 0) begin
      tl_g = tl[g];
      void'(fq[g].pop_front());
      credits--;
      occ++;
      if (owner < 0) begin
        rr = (g + 1) % N;
        owner = tl_g ? -1 : g;
      end else if (tl_g) begin
        owner = -1;
      end
    end
    if (cr) begin
      credits++;
      occ--;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain();
    int budget = 300;
    credit_mode = 1'b1;
    while (!queues_empty() && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      errors++;
      $display("FAIL drain: queues not empty after cycle budget");
    end
    run(2);
  endtask

  // Asynchronous reset with pending heads on every input
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    head_req_i = '1;
    flit_valid_i = '1;
    tail_i = '0;
    credit_i = 1'b0;
    #2;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_sel", 32'(xb_sel_o), 32'd0);
    chk("rst_locked", 32'(locked_o), 32'd0);
    @(posedge clk);
    #2;
    chk("rst_grant_hold", 32'(grant_o), 32'd0);
    head_req_i = '0;
    flit_valid_i = '0;
    for (int i = 0; i < N; i++) fq[i].delete();
    owner = -1;
    rr = 0;
    credits = BS;
    occ = 0;
    rst_n = 1'b1;
  endtask

  // Monitor: compares the DUT against each predicted cycle
  initial begin
    logic [EW-1:0] e;
    logic [N-1:0] e_g;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        e_g = e[EW-1 -: N];
        chk("grant", 32'(grant_o), 32'(e_g));
        chk("out_valid", 32'(out_valid_o), 32'(|e_g));
        chk("locked", 32'(locked_o), 32'(e[0]));
        if (|e_g) chk("xb_sel", 32'(xb_sel_o), 32'(e[3:1]));
      end
    end
  end

  initial begin
    // Reset then a single head on input 2
    do_reset();
    add_pkt(2, 3);
    run(1);
    drain();

    // Fairness: all inputs request with two-flit packets
    do_reset();
    for (int i = 0; i < N; i++) add_pkt(i, 2);
    add_pkt(0, 2);
    credit_mode = 1'b1;
    credit_pct = 100;
    drain();

    // Lock: input 1 streams, input 3 arrives mid-packet
    do_reset();
    add_pkt(1, 6);
    run(2);
    add_pkt(3, 2);
    drain();

    // Reset mid-packet, then credit exhaustion on a 10-flit packet
    add_pkt(1, 6);
    credit_mode = 1'b0;
    run(3);
    do_reset();
    credit_mode = 1'b0;
    add_pkt(0, 10);
    run(12);
    force_credit = 1'b1;
    run(3);
    drain();

    // Credit return coinciding with a send while one credit is left
    do_reset();
    credit_mode = 1'b0;
    add_pkt(2, 12);
    run(7);
    force_credit = 1'b1;
    run(3);
    drain();

`ifdef ARB_HEADTAIL_EN
    // Single-flit packet on input 0 then input 4 wins the next cycle
    do_reset();
    add_pkt(0, 1);
    add_pkt(4, 3);
    drain();
`endif

    // Random traffic
    do_reset();
    credit_mode = 1'b1;
    for (int c = 0; c < 600; c++) begin
      credit_pct = $urandom_range(10, 100);
      for (int i = 0; i < N; i++) begin
        if (fq[i].size() == 0 && $urandom_range(0, 99) < 25) begin
`ifdef ARB_HEADTAIL_EN
          add_pkt(i, $urandom_range(1, 6));
`else
          add_pkt(i, $urandom_range(2, 6));
`endif
        end
      end
      step();
    end
    drain();

    repeat (3) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_output_port_allocator
